uc_secuenciador: RTL
====================

# uc_secuenciador

Control unit for the single-cycle microcontroller datapath: decodes the 6-bit opcode driven by the program memory and generates every datapath select, write-enable and port-enable signal. It adds sequential behaviour on top of plain decoding:
- a WAIT instruction that stalls the PC for a programmable number of cycles, using the 25-bit frequency counter value;
- a single-level CALL/RET tracker that flags nesting errors.

It sits beside the microcontroller top level and drives its control inputs directly.

## Interface
- No parameters; widths are fixed by the datapath (opcode 6, port 2, counter 25).
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction bits [5:0] of current word
- zero  in  1  registered ALU zero flag (result of previous instruction)
- puerto1  in  2  immediate port field (instruction bits [7:6])
- puerto2  in  2  register port field (rd1[1:0])
- contador  in  25  frequency counter value from datapath
- op  out  3  ALU operation
- we3, s_inm, s_inc, s_rel, s_ret, enablebackup  out  1 each  datapath selects/enables
- selentrada, selsalida  out  1 each  input/output muxes
- enable0..enable3  out  1 each  output register enables
- s_cont  out  1  counter load strobe
- pc_hold  out  1  PC register enable inverted (1 = PC keeps value)
- busy  out  1  high while not in RUN
- call_err  out  1  sticky nesting error flag

## Operation
Decode in RUN. Unlisted outputs are 0, and s_inc defaults to 1.
- opcode[5:3]=000, ALU: op=opcode[2:0], we3=1.
- 001000 LOADI: s_inm=1, we3=1.
- 001001 IN: selentrada=1, we3=1.
- 001010 OUT: selsalida=1, enable[puerto2]=1.
- 001011 OUTI: selsalida=0, enable[puerto1]=1.
- 010000 JMP: s_inc=0.
- 010001 JZ: s_inc=~zero.
- 010010 JNZ: s_inc=zero.
- 010011 JREL: s_rel=1.
- 010100 CALL: enablebackup=1, s_inc=0, call_active<=1.
  - If call_active is already 1: call_err<=1, and the backup register is still written.
- 010101 RET, with call_active=1: s_ret=1, call_active<=0.
  - With call_active=0: executes as NOP and sets call_err<=1.
- 011000 WAIT: s_cont=1, pc_hold=1, next state WAIT_LOAD.
- Any other opcode: NOP, meaning the PC increments and nothing is written.

FSM states:
- RUN: decode as above.
- WAIT_LOAD: cnt<=contador, pc_hold=1, next state WAIT_RUN.
- WAIT_RUN:
  - While cnt!=0: cnt<=cnt-1, pc_hold=1.
  - When cnt==0: pc_hold=0, s_inc=1, next state RUN.
- In WAIT_LOAD and WAIT_RUN: we3, all enables, enablebackup and s_cont are 0, and opcode is ignored.

State rules:
- busy = (state!=RUN).
- call_err is sticky and is cleared only by reset.
- cnt is 25 bits and never decrements below 0.

## Timing
- Decode outputs are combinational from opcode, zero and state. Registered state updates on the rising clk edge.
- Reset values, applied at the first edge with reset=1:
  - state=RUN, cnt=0, call_active=0, call_err=0.
  - While reset is high: all enables/writes 0, s_inc=1, pc_hold=0, busy=0.
- WAIT with loaded value N occupies N+3 cycles:
  - 1 cycle in RUN decode;
  - 1 cycle in WAIT_LOAD;
  - N+1 cycles in WAIT_RUN.
  - The PC advances at the end of the last WAIT_RUN cycle.
- N=0 gives a 3-cycle WAIT. N=2^25-1 must complete without wrap.
- contador is sampled in WAIT_LOAD, one cycle after s_cont. Changes to contador after that are ignored.
- Reset asserted during WAIT_LOAD or WAIT_RUN: the next edge returns to RUN with cnt=0, and pc_hold drops in that same cycle.
- zero is the registered flag of the preceding instruction. JZ/JNZ never see the same-cycle ALU result.
- CALL immediately followed by RET: legal. Backup is written at the CALL edge, and RET selects it in the next cycle.

## Configuration
- UC_WAIT_EN defined: WAIT_LOAD/WAIT_RUN, cnt, s_cont and pc_hold logic are present as described.
- UC_WAIT_EN undefined:
  - 011000 decodes as NOP; state is permanently RUN.
  - s_cont=0, pc_hold=0 and busy=0 are constant; no 25-bit counter is synthesised.
  - contador is left unused.

## Test plan
- Reset: hold reset 2 cycles with opcode=011000 -> state RUN, busy=0, pc_hold=0, call_err=0, s_cont=0.
- ALU/IO decode:
  - opcode=000101 -> op=101, we3=1, s_inc=1.
  - opcode=001011 with puerto1=10 -> enable2=1 only, selsalida=0.
  - opcode=001010 with puerto2=11 -> enable3=1, selsalida=1.
- Branches:
  - JZ with zero=1 -> s_inc=0; with zero=0 -> s_inc=1.
  - JNZ gives the inverse.
  - JREL -> s_rel=1, s_inc=1.
- WAIT, contador=5:
  - s_cont high 1 cycle; pc_hold high 7 cycles; busy high 7 cycles; 8 cycles total before the next decode.
  - contador=0 -> 3 cycles.
- Reset mid-WAIT: contador=100, assert reset at WAIT_RUN cycle 10 -> next cycle RUN, pc_hold=0, later WAIT reloads cleanly.
- Call nesting:
  - CALL, CALL -> call_err=1 after the second edge.
  - Reset, then RET without CALL -> s_ret=0, call_err=1.
  - CALL, RET -> s_ret=1, call_err stays 0.
- Build without UC_WAIT_EN: opcode 011000 -> s_inc=1, pc_hold=0, busy=0, all writes 0.

Source files
------------

// File: rtl/uc_secuenciador_if.sv
// Control bundle between the uc_secuenciador control unit and the microcontroller datapath.
// The master side drives the instruction fields; the slave side is the control unit.
interface uc_secuenciador_if;
  logic [5:0]  opcode;
  logic        zero;
  logic [1:0]  puerto1;
  logic [1:0]  puerto2;
  logic [24:0] contador;

  logic [2:0]  op;
  logic        we3;
  logic        s_inm;
  logic        s_inc;
  logic        s_rel;
  logic        s_ret;
  logic        enablebackup;
  logic        selentrada;
  logic        selsalida;
  logic        enable0;
  logic        enable1;
  logic        enable2;
  logic        enable3;
  logic        s_cont;
  logic        pc_hold;
  logic        busy;
  logic        call_err;

  modport master (
    output opcode, zero, puerto1, puerto2, contador,
    input  op, we3, s_inm, s_inc, s_rel, s_ret, enablebackup,
           selentrada, selsalida, enable0, enable1, enable2, enable3,
           s_cont, pc_hold, busy, call_err
  );

  modport slave (
    input  opcode, zero, puerto1, puerto2, contador,
    output op, we3, s_inm, s_inc, s_rel, s_ret, enablebackup,
           selentrada, selsalida, enable0, enable1, enable2, enable3,
           s_cont, pc_hold, busy, call_err
  );
endinterface

// File: rtl/uc_secuenciador.sv
// Control unit: opcode decode plus WAIT stall sequencing and single-level CALL/RET tracking.
// Define UC_WAIT_EN to build the WAIT states and the 25-bit stall counter.
module uc_secuenciador (
  input  logic              clk,
  input  logic              reset,
  uc_secuenciador_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_LOAD = 2'd1,
    WAIT_RUN  = 2'd2
  } state_t;

  state_t     w_state;
  logic       r_callActive;
  logic       r_callErr;
  logic       w_isCall;
  logic       w_isRet;
  logic [3:0] w_enable;

`ifdef UC_WAIT_EN
  state_t      r_state;
  state_t      w_stateNext;
  logic [24:0] r_cnt;
  logic [24:0] w_cntNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  assign w_state = r_state;
`else
  assign w_state = RUN;
`endif

  // Outputs are forced to their idle values while reset is high, so a reset
  // during a stall releases the PC in the same cycle.
  always_comb begin
    bus.op           = 3'b000;
    bus.we3          = 1'b0;
    bus.s_inm        = 1'b0;
    bus.s_inc        = 1'b1;
    bus.s_rel        = 1'b0;
    bus.s_ret        = 1'b0;
    bus.enablebackup = 1'b0;
    bus.selentrada   = 1'b0;
    bus.selsalida    = 1'b0;
    bus.s_cont       = 1'b0;
    bus.pc_hold      = 1'b0;
    w_enable         = 4'b0000;
    w_isCall         = 1'b0;
    w_isRet          = 1'b0;
`ifdef UC_WAIT_EN
    w_stateNext      = r_state;
    w_cntNext        = r_cnt;
`endif
    if (!reset) begin
      case (w_state)
        RUN: begin
          if (bus.opcode[5:3] == 3'b000) begin
            bus.op  = bus.opcode[2:0];
            bus.we3 = 1'b1;
          end else begin
            case (bus.opcode)
              6'b001000: begin
                bus.s_inm = 1'b1;
                bus.we3   = 1'b1;
              end
              6'b001001: begin
                bus.selentrada = 1'b1;
                bus.we3        = 1'b1;
              end
              6'b001010: begin
                bus.selsalida = 1'b1;
                w_enable      = 4'b0001 << bus.puerto2;
              end
              6'b001011: w_enable  = 4'b0001 << bus.puerto1;
              6'b010000: bus.s_inc = 1'b0;
              6'b010001: bus.s_inc = ~bus.zero;
              6'b010010: bus.s_inc = bus.zero;
              6'b010011: bus.s_rel = 1'b1;
              6'b010100: begin
                bus.enablebackup = 1'b1;
                bus.s_inc        = 1'b0;
                w_isCall         = 1'b1;
              end
              // A RET with no open CALL falls through as a NOP.
              6'b010101: begin
                w_isRet   = 1'b1;
                bus.s_ret = r_callActive;
              end
`ifdef UC_WAIT_EN
              6'b011000: begin
                bus.s_cont  = 1'b1;
                bus.pc_hold = 1'b1;
                w_stateNext = WAIT_LOAD;
              end
`endif
              default: ;
            endcase
          end
        end
`ifdef UC_WAIT_EN
        WAIT_LOAD: begin
          bus.pc_hold = 1'b1;
          w_cntNext   = bus.contador;
          w_stateNext = WAIT_RUN;
        end
        // The PC is released on the cycle the count reaches zero.
        WAIT_RUN: begin
          if (r_cnt != 25'd0) begin
            bus.pc_hold = 1'b1;
            w_cntNext   = r_cnt - 25'd1;
          end else begin
            w_stateNext = RUN;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_callActive <= 1'b0;
      r_callErr    <= 1'b0;
    end else if (w_isCall) begin
      r_callActive <= 1'b1;
      if (r_callActive) begin
        r_callErr <= 1'b1;
      end
    end else if (w_isRet) begin
      if (r_callActive) begin
        r_callActive <= 1'b0;
      end else begin
        r_callErr <= 1'b1;
      end
    end
  end

  assign bus.enable0  = w_enable[0];
  assign bus.enable1  = w_enable[1];
  assign bus.enable2  = w_enable[2];
  assign bus.enable3  = w_enable[3];
  assign bus.busy     = (~reset) & (w_state != RUN);
  assign bus.call_err = r_callErr;

endmodule
